// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780-style character LCD controller.
//   After reset it waits PWRUP_CYCLES and then sends the 5-byte init sequence
//   on its own. After that it drains a command/data FIFO onto the LCD pins,
//   giving each byte a SETUP / EN pulse / HOLD cycle. Every timer is loaded
//   with N-1 and counts down to 0, so each phase lasts exactly N clocks.
//
// Optional feature (macro LCD_CHAR_CTRL_WRAP_EN): the controller tracks the
//   cursor position. When a line fills up, it inserts a set-DDRAM-address
//   command that moves the cursor to the start of the next line.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET       in   synchronous active-high reset
//   wr_valid    in   write request
//   wr_rs       in   1 = character data, 0 = command
//   wr_data     in   byte to send
//   wr_ready    out  FIFO not full (registered)
//   init_done   out  init sequence complete
//   busy        out  engine active or FIFO non-empty
//   fifo_count  out  occupied FIFO entries
//   LCD_DATA    out  LCD data bus
//   LCD_RW      out  read/write select, tied to 0 (write only)
//   LCD_RS      out  register select
//   LCD_EN      out  enable strobe
//   LCD_ON      out  panel power
//   LCD_BLON    out  backlight
//
// State table:
//   PWRUP  | power-up wait before the first init write
//   ISETUP | init byte driven, EN low (1 clk)
//   IPULSE | init byte strobe, EN high
//   IHOLD  | init byte execution time
//   IDLE   | waiting for a FIFO entry (or an inserted wrap command)
//   SETUP  | byte driven, EN low (1 clk)
//   PULSE  | strobe, EN high
//   HOLD   | execution time (clear/home get the long hold)
module lcd_char_ctrl #(
  parameter int PWRUP_CYCLES   = 750000,
  parameter int EN_CYCLES      = 25,
  parameter int CMD_CYCLES     = 2500,
  parameter int CLR_CYCLES     = 82000,
  parameter int FIFO_DEPTH     = 16,
  parameter int CHARS_PER_LINE = 16,
  parameter int LINES          = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          wr_valid,
  input  logic                          wr_rs,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          init_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    LCD_DATA,
  output logic                          LCD_RW,
  output logic                          LCD_RS,
  output logic                          LCD_EN,
  output logic                          LCD_ON,
  output logic                          LCD_BLON
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int M1 = (PWRUP_CYCLES > CLR_CYCLES) ? PWRUP_CYCLES : CLR_CYCLES;
  localparam int M2 = (CMD_CYCLES > EN_CYCLES) ? CMD_CYCLES : EN_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MAXC) + 1;
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_char_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end
  if (LINES < 1 || LINES > 2 || CHARS_PER_LINE < 1 || CHARS_PER_LINE > 64) begin : g_bad_geom
    $error("lcd_char_ctrl: LINES must be 1 or 2, CHARS_PER_LINE 1..64");
  end

  typedef enum logic [2:0] {
    S_PWRUP, S_ISETUP, S_IPULSE, S_IHOLD, S_IDLE, S_SETUP, S_PULSE, S_HOLD
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tmr, tmr_load_val, hold_len;
  logic            tmr_load, tmr_zero;
  logic [2:0]      rom_idx;
  logic [7:0]      cur_data, ld_data;
  logic            cur_rs, ld_rs, ld;
  logic            init_adv, init_fin, lcd_on;
  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_next;
  logic            push, pop;

  function automatic logic [7:0] rom_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1: rom_byte = 8'h38;
      3'd2:       rom_byte = 8'h0C;
      3'd3:       rom_byte = 8'h01;
      default:    rom_byte = 8'h06;
    endcase
  endfunction

  assign tmr_zero = (tmr == '0);
  assign hold_len = (!cur_rs && (cur_data == 8'h01 || cur_data == 8'h02 || cur_data == 8'h03))
                    ? TW'(CLR_CYCLES - 1) : TW'(CMD_CYCLES - 1);

  assign push       = wr_valid & wr_ready;
  assign count_next = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

`ifdef LCD_CHAR_CTRL_WRAP_EN
  logic [6:0] col;
  logic       line, line_next, wrap_pending, ins;
  logic [7:0] wrap_cmd;

  assign line_next = (LINES == 2) ? ~line : 1'b0;
  assign wrap_cmd  = line_next ? 8'hC0 : 8'h80;
`endif

  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    pop          = 1'b0;
    ld           = 1'b0;
    ld_data      = cur_data;
    ld_rs        = cur_rs;
    init_adv     = 1'b0;
    init_fin     = 1'b0;
`ifdef LCD_CHAR_CTRL_WRAP_EN
    ins          = 1'b0;
`endif
    case (state)
      S_PWRUP: if (tmr_zero) begin
        state_next = S_ISETUP;
        ld         = 1'b1;
        ld_data    = rom_byte(3'd0);
        ld_rs      = 1'b0;
      end
      S_ISETUP: begin
        state_next   = S_IPULSE;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(EN_CYCLES - 1);
      end
      S_IPULSE: if (tmr_zero) begin
        state_next   = S_IHOLD;
        tmr_load     = 1'b1;
        tmr_load_val = hold_len;
      end
      S_IHOLD: if (tmr_zero) begin
        if (rom_idx == 3'd4) begin
          state_next = S_IDLE;
          init_fin   = 1'b1;
        end else begin
          state_next = S_ISETUP;
          init_adv   = 1'b1;
          ld         = 1'b1;
          ld_data    = rom_byte(rom_idx + 3'd1);
          ld_rs      = 1'b0;
        end
      end
      S_IDLE: begin
`ifdef LCD_CHAR_CTRL_WRAP_EN
        // A pending wrap command takes priority over the FIFO head.
        if (wrap_pending) begin
          ins        = 1'b1;
          ld         = 1'b1;
          ld_data    = wrap_cmd;
          ld_rs      = 1'b0;
          state_next = S_SETUP;
        end else
`endif
        if (fifo_count != '0) begin
          pop        = 1'b1;
          ld         = 1'b1;
          ld_data    = mem[rd_ptr][7:0];
          ld_rs      = mem[rd_ptr][8];
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        state_next   = S_PULSE;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(EN_CYCLES - 1);
      end
      S_PULSE: if (tmr_zero) begin
        state_next   = S_HOLD;
        tmr_load     = 1'b1;
        tmr_load_val = hold_len;
      end
      S_HOLD: if (tmr_zero) state_next = S_IDLE;
      default: state_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state      <= S_PWRUP;
      tmr        <= TW'(PWRUP_CYCLES - 1);
      rom_idx    <= '0;
      cur_data   <= '0;
      cur_rs     <= 1'b0;
      init_done  <= 1'b0;
      lcd_on     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wr_ready   <= 1'b1;
    end else begin
      state  <= state_next;
      lcd_on <= 1'b1;
      if (tmr_load)
        tmr <= tmr_load_val;
      else if (!tmr_zero)
        tmr <= tmr - 1'b1;
      if (ld) begin
        cur_data <= ld_data;
        cur_rs   <= ld_rs;
      end
      if (init_adv) rom_idx <= rom_idx + 3'd1;
      if (init_fin) init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      // Registered full flag: a pop on a full FIFO frees the slot only from the next cycle.
      wr_ready   <= (count_next != FULL);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {wr_rs, wr_data};
  end

`ifdef LCD_CHAR_CTRL_WRAP_EN
  // The tracker follows every byte taken from IDLE, including the inserted
  // command: its bit-7 address load moves the cursor to (0, line_next).
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      col          <= '0;
      line         <= 1'b0;
      wrap_pending <= 1'b0;
    end else if (pop || ins) begin
      if (ins) wrap_pending <= 1'b0;
      if (ld_rs) begin
        col <= col + 7'd1;
        if (col + 7'd1 == 7'(CHARS_PER_LINE)) wrap_pending <= 1'b1;
      end else if (ld_data == 8'h01 || ld_data == 8'h02 || ld_data == 8'h03) begin
        col  <= '0;
        line <= 1'b0;
      end else if (ld_data[7]) begin
        col  <= {1'b0, ld_data[5:0]};
        line <= ld_data[6];
      end
    end
  end

  assign busy = !(state == S_IDLE && fifo_count == '0 && init_done && !wrap_pending);
`else
  assign busy = !(state == S_IDLE && fifo_count == '0 && init_done);
`endif

  assign LCD_DATA = cur_data;
  assign LCD_RS   = cur_rs;
  assign LCD_EN   = (state == S_IPULSE) || (state == S_PULSE);
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = lcd_on;
  assign LCD_BLON = lcd_on;

endmodule
